// File: rtl/seq_div_unit.sv
// Multicycle signed divider: restoring division on magnitudes, one quotient bit per clock, then a sign-fix cycle.
// Optional macro DIVU_EN adds the div_unsigned input for unsigned (DIVU) operation.
//
// state | meaning
// IDLE  | waiting for div_start; operands captured here
// RUN   | one restoring-division step per clock, WIDTH steps
// SIGN  | apply result signs, write div_lo/div_hi
// DONE  | div_fim high for this single cycle
module seq_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_start,
`ifdef DIVU_EN
  input  logic             div_unsigned,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] div_hi,
  output logic             div_fim,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } divStateT;

  divStateT         state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] dvdReg;
  logic [WIDTH-1:0] divisorReg;
  logic             signQ;
  logic             signR;

  logic             isUnsigned;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trialDiff;
  logic             trialGeq;

`ifdef DIVU_EN
  assign isUnsigned = div_unsigned;
`else
  assign isUnsigned = 1'b0;
`endif

  // Negating -2^(WIDTH-1) yields the same bit pattern, which read unsigned is exactly its magnitude.
  assign aMag = (!isUnsigned && a_in[WIDTH-1]) ? -a_in : a_in;
  assign bMag = (!isUnsigned && b_in[WIDTH-1]) ? -b_in : b_in;

  // The partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
  // and the top bit of the difference acts as the borrow.
  assign shifted   = {remReg, dvdReg[WIDTH-1]};
  assign trialDiff = shifted - {1'b0, divisorReg};
  assign trialGeq  = ~trialDiff[WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= '0;
      remReg     <= '0;
      dvdReg     <= '0;
      divisorReg <= '0;
      signQ      <= 1'b0;
      signR      <= 1'b0;
      div_lo     <= '0;
      div_hi     <= '0;
      div_fim    <= 1'b0;
      div_zero   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      div_fim <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            if (b_in == '0) begin
              div_zero <= 1'b1;
              div_fim  <= 1'b1;
              state    <= DONE;
            end else begin
              dvdReg     <= aMag;
              divisorReg <= bMag;
              remReg     <= '0;
              signQ      <= !isUnsigned && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
              signR      <= !isUnsigned && a_in[WIDTH-1];
              counter    <= CNT_INIT;
              div_zero   <= 1'b0;
              busy       <= 1'b1;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          remReg  <= trialGeq ? trialDiff[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvdReg  <= {dvdReg[WIDTH-2:0], trialGeq};
          counter <= counter - CNT_ONE;
          if (counter == CNT_ONE) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          div_lo  <= signQ ? -dvdReg : dvdReg;
          div_hi  <= signR ? -remReg : remReg;
          busy    <= 1'b0;
          div_fim <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_unit.sv
// Randomized scoreboard bench for seq_div_unit; expected results come from plain 64-bit arithmetic.
module tb_seq_div_unit;
  localparam int WIDTH = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              div_start = 1'b0;
`ifdef DIVU_EN
  logic              divUnsigned = 1'b0;
`endif
  logic [WIDTH-1:0]  a_in = '0;
  logic [WIDTH-1:0]  b_in = '0;
  logic [WIDTH-1:0]  div_lo;
  logic [WIDTH-1:0]  div_hi;
  logic              div_fim;
  logic              div_zero;
  logic              busy;

  typedef struct {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             zero;
    int               startCyc;
    int               lat;
  } expT;

  expT              expQ[$];
  int               checks = 0;
  int               errors = 0;
  int               cycleCnt = 0;
  logic [WIDTH-1:0] mLo = '0;
  logic [WIDTH-1:0] mHi = '0;

  seq_div_unit #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .div_start(div_start),
`ifdef DIVU_EN
    .div_unsigned(divUnsigned),
`endif
    .a_in(a_in),
    .b_in(b_in),
    .div_lo(div_lo),
    .div_hi(div_hi),
    .div_fim(div_fim),
    .div_zero(div_zero),
    .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycleCnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every div_fim must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && div_fim) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fim actual=1 expected=0 at cycle %0d", cycleCnt);
      end else begin
        expT e;
        e = expQ.pop_front();
        chk("div_lo", div_lo, e.lo);
        chk("div_hi", div_hi, e.hi);
        chk("div_zero", {31'b0, div_zero}, {31'b0, e.zero});
        chk("latency", WIDTH'(cycleCnt - e.startCyc), WIDTH'(e.lat));
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic uns);
    expT    e;
    longint sa, sb;
    @(negedge clock);
    a_in = a;
    b_in = b;
`ifdef DIVU_EN
    divUnsigned = uns;
`endif
    div_start = 1'b1;
    @(posedge clock);
    #1;
    div_start = 1'b0;
    if (b == '0) begin
      e.zero = 1'b1;
      e.lat  = 0;
    end else begin
      if (uns) begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end
      mLo = WIDTH'(sa / sb);
      mHi = WIDTH'(sa % sb);
      e.zero = 1'b0;
      e.lat  = WIDTH + 1;
    end
    e.lo = mLo;
    e.hi = mHi;
    e.startCyc = cycleCnt;
    expQ.push_back(e);
    if (b != '0) begin
      @(negedge clock);
      chk("busy_run", {31'b0, busy}, 32'd1);
    end
  endtask

  // Waits until the scoreboard drains and the DUT is idle; operand inputs churn meanwhile.
  task automatic waitDone();
    int n = 0;
    while ((expQ.size() != 0 || busy || div_fim) && n < 200) begin
      @(negedge clock);
      a_in = $urandom;
      b_in = $urandom;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d expected<200 cycles pending=%0d", n, expQ.size());
      expQ.delete();
    end
  endtask

  function automatic logic [WIDTH-1:0] randOperand();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0: v = WIDTH'($urandom_range(0, 20));
      1: v = -WIDTH'($urandom_range(1, 20));
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             ru;

    repeat (3) @(negedge clock);
    chk("rst_lo", div_lo, '0);
    chk("rst_hi", div_hi, '0);
    chk("rst_flags", {29'b0, div_fim, div_zero, busy}, '0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    issue(32'd7, 32'd2, 1'b0);                waitDone();
    issue(32'd5, 32'd0, 1'b0);                waitDone();
    issue(32'hFFFF_FFF9, 32'd2, 1'b0);        waitDone();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0); waitDone();
    issue(32'd0, 32'd9, 1'b0);                waitDone();
    issue(32'd3, 32'hFFFF_FFF9, 1'b0);        waitDone();

    // Second start in RUN is ignored; reset mid-operation aborts without div_fim.
    @(negedge clock);
    a_in = 32'd100;
    b_in = 32'd7;
    div_start = 1'b1;
    @(posedge clock);
    #1;
    div_start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    div_start = 1'b1;
    a_in = 32'd1;
    b_in = 32'd1;
    @(posedge clock);
    #1;
    div_start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("busy_before_reset", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_lo", div_lo, '0);
    chk("abort_hi", div_hi, '0);
    chk("abort_flags", {29'b0, div_fim, div_zero, busy}, '0);
    mLo = '0;
    mHi = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("no_fim_after_abort", {31'b0, busy}, '0);
    issue(32'd100, 32'd7, 1'b0);              waitDone();
    issue(32'd4, 32'd0, 1'b0);                waitDone();

`ifdef DIVU_EN
    issue(32'hFFFF_FFFF, 32'd2, 1'b1);        waitDone();
    issue(32'hFFFF_FFFF, 32'd2, 1'b0);        waitDone();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); waitDone();
`endif

    for (int i = 0; i < 40; i++) begin
      ra = randOperand();
      rb = ($urandom_range(0, 7) == 0) ? '0 : randOperand();
      ru = 1'b0;
`ifdef DIVU_EN
      ru = 1'($urandom_range(0, 1));
`endif
      issue(ra, rb, ru);
      waitDone();
    end

    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
